// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter mode constants.
// Imported by the counter, its load-path converter and the bench.
package gray_pkg;

  localparam bit WRAP_EN  = 1'b1;
  localparam bit WRAP_SAT = 1'b0;

  localparam int GMAX = 32;

  // Operates on a zero-extended 32-bit value.
  // The zero upper bits keep the low bits exact for any width.
  function automatic logic [GMAX-1:0] bin_to_gray(
    input logic [GMAX-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GMAX-1:0] gray_to_bin(
    input logic [GMAX-1:0] g
  );
    logic [GMAX-1:0] b;
    b = '0;
    b[GMAX-1] = g[GMAX-1];
    for (int i = GMAX-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and status bundle of the Gray counter.
// The master drives control; the counter drives status.
interface gray_counter_if #(
  parameter int N = 4
);

  logic         en;
  logic         up;
  logic         load;
  logic         load_gray;
  logic [N-1:0] load_val;
  logic [N-1:0] bin;
  logic [N-1:0] gray;
  logic         tc;

  modport master (
    output en,
    output up,
    output load,
    output load_gray,
    output load_val,
    input  bin,
    input  gray,
    input  tc
  );

  modport slave (
    input  en,
    input  up,
    input  load,
    input  load_gray,
    input  load_val,
    output bin,
    output gray,
    output tc
  );

endinterface

// File: rtl/gray_conv.sv
// Combinational Gray-to-binary converter for the load path.
// b[N-1] = g[N-1], b[i] = b[i+1] ^ g[i].
module gray_conv
  import gray_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] g_in,
  output logic [N-1:0] b_out
);

  logic [GMAX-1:0] g_ext;
  logic [GMAX-1:0] b_ext;

  always_comb begin
    g_ext = '0;
    g_ext[N-1:0] = g_in;
    b_ext = gray_to_bin(g_ext);
  end

  assign b_out = b_ext[N-1:0];

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray and terminal-count outputs.
// Wraps or saturates at the range ends depending on WRAP.
module gray_counter
  import gray_pkg::*;
#(
  parameter int N    = 4,
  parameter bit WRAP = WRAP_EN
) (
  input logic           clk,
  input logic           rst,
  gray_counter_if.slave bus
);

  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] TOP  = '1;

  logic [N-1:0] bin_q;
  logic [N-1:0] gray_q;
  logic         tc_q;

  logic [N-1:0] load_bin;
  logic [N-1:0] conv_bin;
  logic [N-1:0] stepped;
  logic [N-1:0] cnt_next;
  logic         edge_hit;
  logic         tc_cnt;

  gray_conv #(
    .N(N)
  ) u_conv (
    .g_in (bus.load_val),
    .b_out(conv_bin)
  );

  assign load_bin = bus.load_gray ? conv_bin : bus.load_val;

  function automatic logic [N-1:0] to_gray(
    input logic [N-1:0] b
  );
    logic [GMAX-1:0] e;
    logic [GMAX-1:0] g;
    e = '0;
    e[N-1:0] = b;
    g = bin_to_gray(e);
    return g[N-1:0];
  endfunction

  always_comb begin
    edge_hit = 1'b0;
    stepped  = bin_q;
    cnt_next = bin_q;
    tc_cnt   = 1'b0;
    unique case (1'b1)
      bus.up: begin
        edge_hit = (bin_q == TOP);
        stepped  = bin_q + ONE;
      end
      default: begin
        edge_hit = (bin_q == ZERO);
        stepped  = bin_q - ONE;
      end
    endcase
    if (WRAP == WRAP_EN) begin
      cnt_next = stepped;
      tc_cnt   = edge_hit;
    end else begin
      // Saturate: flag stays up while parked at the bound.
      cnt_next = edge_hit ? bin_q : stepped;
      tc_cnt   = bus.up ? (cnt_next == TOP)
                        : (cnt_next == ZERO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else if (bus.load) begin
      bin_q  <= load_bin;
      gray_q <= to_gray(load_bin);
      tc_q   <= 1'b0;
    end else if (bus.en) begin
      bin_q  <= cnt_next;
      gray_q <= to_gray(cnt_next);
      tc_q   <= tc_cnt;
    end else begin
      tc_q   <= 1'b0;
    end
  end

  assign bus.bin  = bin_q;
  assign bus.gray = gray_q;
  assign bus.tc   = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed checks on N=4 wrap/saturate counters plus an N=8 soak.
// Expected values are hand tables or an independent model.
module tb_gray_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  gray_counter_if #(.N(4)) w4 ();
  gray_counter_if #(.N(4)) s4 ();
  gray_counter_if #(.N(8)) w8 ();

  gray_counter #(.N(4), .WRAP(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .bus(w4)
  );
  gray_counter #(.N(4), .WRAP(1'b0)) u_s4 (
    .clk(clk), .rst(rst), .bus(s4)
  );
  gray_counter #(.N(8), .WRAP(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .bus(w8)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    w4.en = 0; w4.up = 1; w4.load = 0;
    w4.load_gray = 0; w4.load_val = '0;
    s4.en = 0; s4.up = 1; s4.load = 0;
    s4.load_gray = 0; s4.load_val = '0;
    w8.en = 0; w8.up = 1; w8.load = 0;
    w8.load_gray = 0; w8.load_val = '0;
  endtask

  function automatic logic [7:0] g2b8(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    return b;
  endfunction

  logic [31:0] gseq [18];
  logic [7:0]  mb, mg, pg, dg;
  logic        mt, counted;

  initial begin
    gseq = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13,
             15, 14, 10, 11, 9, 8, 0, 1};
    idle_all();

    // Reset overrides a concurrent load.
    rst = 1; w4.load = 1; w4.load_val = 4'd9;
    step();
    rst = 0; w4.load = 0;
    chk("rst_bin", 32'(w4.bin), 0);
    chk("rst_gray", 32'(w4.gray), gseq[0]);
    chk("rst_tc", 32'(w4.tc), 0);
    chk("rst_s4", 32'(s4.bin), 0);

    // Full up sequence with wrap.
    w4.en = 1; w4.up = 1;
    for (int k = 1; k < 18; k++) begin
      step();
      chk($sformatf("seq_g%0d", k), 32'(w4.gray), gseq[k]);
      chk($sformatf("seq_tc%0d", k), 32'(w4.tc),
          (k == 16) ? 32'd1 : 32'd0);
    end

    // Hold with en low.
    w4.en = 0;
    step();
    chk("hold_g", 32'(w4.gray), 1);
    chk("hold_tc", 32'(w4.tc), 0);

    // Down wrap 0 -> 15.
    w4.en = 1; w4.up = 0;
    step();
    chk("dn_bin0", 32'(w4.bin), 0);
    step();
    chk("dn_wrap", 32'(w4.bin), 15);
    chk("dn_wrap_g", 32'(w4.gray), 8);
    chk("dn_wrap_tc", 32'(w4.tc), 1);
    step();
    chk("dn_14", 32'(w4.bin), 14);
    chk("dn_14_tc", 32'(w4.tc), 0);

    // Gray load then one down step.
    w4.en = 0;
    w4.load = 1; w4.load_gray = 1; w4.load_val = 4'b1100;
    step();
    w4.load = 0; w4.load_gray = 0;
    chk("ldg_bin", 32'(w4.bin), 8);
    chk("ldg_gray", 32'(w4.gray), 12);
    chk("ldg_tc", 32'(w4.tc), 0);
    w4.en = 1; w4.up = 0;
    step();
    w4.en = 0;
    chk("ldg_dn_bin", 32'(w4.bin), 7);
    chk("ldg_dn_gray", 32'(w4.gray), 4);

    // Load beats enable.
    w4.en = 1; w4.up = 1;
    w4.load = 1; w4.load_val = 4'd5;
    step();
    w4.load = 0;
    chk("ldw_bin", 32'(w4.bin), 5);
    step();
    chk("ldw_next", 32'(w4.bin), 6);

    // Direction change with no idle cycle.
    w4.up = 0;
    step();
    chk("dir_bin", 32'(w4.bin), 5);
    w4.en = 0;

    // Load at 15 then wrap shows tc cleared by load.
    w4.load = 1; w4.load_val = 4'd15;
    step();
    w4.load = 0;
    chk("ld15_tc", 32'(w4.tc), 0);

    // Reset mid-count at 9 with en held high.
    rst = 1; step(); rst = 0;
    w4.en = 1; w4.up = 1;
    for (int k = 0; k < 9; k++) step();
    chk("mid_9", 32'(w4.bin), 9);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_bin", 32'(w4.bin), 0);
    chk("mid_rst_gray", 32'(w4.gray), 0);
    chk("mid_rst_tc", 32'(w4.tc), 0);
    step();
    chk("mid_1", 32'(w4.bin), 1);
    step();
    chk("mid_2", 32'(w4.bin), 2);
    w4.en = 0;

    // Saturating counter at the top bound.
    s4.load = 1; s4.load_val = 4'd14;
    step();
    s4.load = 0;
    chk("sat_ld", 32'(s4.bin), 14);
    s4.en = 1; s4.up = 1;
    step();
    chk("sat_b1", 32'(s4.bin), 15);
    chk("sat_t1", 32'(s4.tc), 1);
    step();
    chk("sat_b2", 32'(s4.bin), 15);
    chk("sat_t2", 32'(s4.tc), 1);
    step();
    chk("sat_b3", 32'(s4.bin), 15);
    chk("sat_g3", 32'(s4.gray), 8);
    s4.up = 0;
    step();
    chk("sat_dn", 32'(s4.bin), 14);
    chk("sat_dn_tc", 32'(s4.tc), 0);
    s4.en = 0;
    step();
    chk("sat_off_tc", 32'(s4.tc), 0);

    // Saturating counter at the bottom bound.
    s4.load = 1; s4.load_val = 4'd1;
    step();
    s4.load = 0;
    s4.en = 1; s4.up = 0;
    step();
    chk("satlo_b1", 32'(s4.bin), 0);
    chk("satlo_t1", 32'(s4.tc), 1);
    step();
    chk("satlo_b2", 32'(s4.bin), 0);
    chk("satlo_t2", 32'(s4.tc), 1);
    s4.en = 0;

    // N=8 random soak against an independent model.
    rst = 1; step(); rst = 0;
    mb = 0; mt = 0; pg = 0;
    for (int c = 0; c < 1000; c++) begin
      w8.en        = ($urandom_range(0, 9) != 0);
      w8.up        = ($urandom_range(0, 3) != 0);
      w8.load      = ($urandom_range(0, 24) == 0);
      w8.load_gray = $urandom_range(0, 1);
      w8.load_val  = 8'($urandom);
      counted = 0;
      if (w8.load) begin
        mb = w8.load_gray ? g2b8(w8.load_val) : w8.load_val;
        mt = 0;
      end else if (w8.en) begin
        mt = w8.up ? (mb == 8'hff) : (mb == 8'h00);
        mb = w8.up ? mb + 8'd1 : mb - 8'd1;
        counted = 1;
      end else begin
        mt = 0;
      end
      mg = mb ^ (mb >> 1);
      step();
      chk("soak_bin", 32'(w8.bin), 32'(mb));
      chk("soak_gray", 32'(w8.gray), 32'(mg));
      chk("soak_enc", 32'(w8.gray),
          32'(w8.bin ^ (w8.bin >> 1)));
      chk("soak_tc", 32'(w8.tc), 32'(mt));
      if (counted) begin
        dg = w8.gray ^ pg;
        chk("soak_1bit", 32'($countones(dg)), 1);
      end
      pg = w8.gray;
    end
    idle_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter: N, default 4, counter width in bits; legal range 2..32.
REQ-002 Parameter: WRAP, default 1; 1 means the count wraps at the range ends, 0 means it saturates there.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: en  input  1  count enable; one step per cycle while high.
REQ-006 Port: up  input  1  direction; 1 counts up, 0 counts down; sampled only when counting.
REQ-007 Port: load  input  1  synchronous load strobe.
REQ-008 Port: load_gray  input  1  encoding of load_val; 1 means Gray, 0 means binary.
REQ-009 Port: load_val  input  N  load value.
REQ-010 Port: bin  output  N  current count, binary, registered.
REQ-011 Port: gray  output  N  current count, Gray-encoded, registered.
REQ-012 Port: tc  output  1  terminal-count flag, registered.

Function
REQ-013 State SHALL be one N-bit binary register plus the registered gray and tc outputs; gray SHALL always equal bin ^ (bin >> 1) in the same cycle.
REQ-014 Per-edge priority SHALL be: rst, then load, then en, then hold.
REQ-015 On load, bin SHALL take load_val directly when load_gray=0.
REQ-016 On load with load_gray=1, bin SHALL take the Gray-to-binary conversion of load_val: b[N-1]=g[N-1], b[i]=b[i+1]^g[i].
REQ-017 Load SHALL take effect on the next edge regardless of en; tc SHALL be 0 in the cycle after a load.
REQ-018 When en=1 and load=0, bin SHALL step by +1 (up=1) or -1 (up=0), with one-cycle latency from the sampling edge to the outputs.
REQ-019 With WRAP=1, up from 2^N-1 SHALL give 0, and down from 0 SHALL give 2^N-1.
REQ-020 With WRAP=1, tc SHALL pulse high for exactly the one cycle in which the wrapped value is presented.
REQ-021 With WRAP=0, an up step at 2^N-1 or a down step at 0 SHALL leave bin unchanged.
REQ-022 With WRAP=0, tc SHALL be high while en=1 and the count sits at the bound in the current direction, and low otherwise.
REQ-023 Between consecutive counted values (no load), gray SHALL differ in exactly one bit, including across the wrap.
REQ-024 When en=0 and load=0, all outputs SHALL hold, and tc SHALL be 0 (WRAP=1) or held per REQ-022 (WRAP=0).
REQ-025 A direction change SHALL take effect on the step in which it is sampled, with no idle cycle.

Reset
REQ-026 On a rising clk edge with rst=1, bin, gray and tc SHALL all become 0, overriding load and en.
REQ-027 Asserting rst mid-count SHALL discard the count; the first step after rst falls SHALL be taken from 0.
REQ-028 There SHALL be no asynchronous reset path; behaviour before the first reset edge is undefined.

Structure
REQ-029 A shared package gray_pkg SHALL hold the Gray-to-binary and binary-to-Gray conversion functions and the mode constants WRAP_EN and WRAP_SAT.
REQ-030 One combinational sub-module gray_conv (parameter N; ports g_in, b_out) SHALL implement the REQ-016 conversion for the load path.
REQ-031 The top-level RTL SHALL fit within 120-400 lines.

Verification (N=4 unless stated)
REQ-032 Reset then en=1, up=1 for 18 cycles -> gray sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0,1; tc high only at the 0 following 8.
REQ-033 load=1, load_gray=1, load_val=4'b1100 -> next cycle bin=8, gray=12; then one down step -> bin=7, gray=4.
REQ-034 WRAP=0: load binary 14, then en=1, up=1 for 3 cycles -> bin goes 15,15,15; tc high from the first 15 while en=1; up=0 then steps down to 14.
REQ-035 load=1 together with en=1, up=1, load_val=5 (binary) -> bin=5 (load wins); next step -> 6.
REQ-036 rst pulsed mid-count at bin=9 with en held high -> outputs 0 on the reset edge, then 1, 2 afterwards.
REQ-037 N=8 random 1000-cycle soak -> a scoreboard confirms REQ-013 and REQ-023 on every cycle.
